// File: rtl/ifft_butterfly_4_seq.sv
// Sequential radix-4 inverse-FFT butterfly.
// Frequency-domain bins a..d come in, time-domain samples out0..out3 go out.
// b, c and d are multiplied by the conjugated twiddles w0, w1 and w2. One
// complex multiplier is shared across three cycles. The +j/-j rotation roles
// are swapped compared with the forward butterfly.
// Optional build macro IFFT_BFLY_SCALE_EN: each combine sum is formed two bits
// wider, then shifted right arithmetically by 2. This gives the 1/4 per-stage
// scaling of the inverse transform. Without the macro the sums wrap at WIDTH/2 bits.
//
//   state | meaning
//   ------+----------------------------------------------------------
//   IDLE  | waiting for an operand set; in_ready high
//   MUL0  | t1 = b * conj(w0) through the shared multiplier
//   MUL1  | t2 = c * conj(w1)
//   MUL2  | t3 = d * conj(w2)
//   SUM   | radix-4 combine into out0..out3, raise out_valid
//   OUT   | hold results until out_ready; may accept next set same edge

module ifft_butterfly_4_seq #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [WIDTH-1:0] c,
   input  logic [WIDTH-1:0] d,
   input  logic [WIDTH+1:0] w0,
   input  logic [WIDTH+1:0] w1,
   input  logic [WIDTH+1:0] w2,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out0,
   output logic [WIDTH-1:0] out1,
   output logic [WIDTH-1:0] out2,
   output logic [WIDTH-1:0] out3
);

   localparam int H  = WIDTH / 2;   // component width
   localparam int PW = WIDTH + 2;   // full-precision product width
   localparam int SW = H + 2;       // combine sum width (never overflows)

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_MUL0 = 3'd1,
      S_MUL1 = 3'd2,
      S_MUL2 = 3'd3,
      S_SUM  = 3'd4,
      S_OUT  = 3'd5
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d, c_q, c_d, d_q, d_d;
   logic [PW-1:0]    w0_q, w0_d, w1_q, w1_d, w2_q, w2_d;
   logic [WIDTH-1:0] t1_q, t1_d, t2_q, t2_d, t3_q, t3_d;
   logic [WIDTH-1:0] out0_q, out0_d, out1_q, out1_d;
   logic [WIDTH-1:0] out2_q, out2_d, out3_q, out3_d;
   logic             out_valid_q, out_valid_d;

   logic             accept;
   logic [WIDTH-1:0] mul_x;
   logic [PW-1:0]    mul_w;
   logic signed [PW-1:0] mul_xr, mul_xi, mul_wr, mul_wi;
   logic signed [PW-1:0] prod_r, prod_i;
   logic [WIDTH-1:0] mul_t;

   logic signed [SW-1:0] s0r, s0i, s1r, s1i, s2r, s2i, s3r, s3i;

   // Sign-extend one WIDTH/2 component to the combine width.
   function automatic logic signed [SW-1:0] ext_h(input logic [H-1:0] v);
      return {{2{v[H-1]}}, v};
   endfunction

   // Reduce a combine sum back to a WIDTH/2 component.
   function automatic logic [H-1:0] fit(input logic signed [SW-1:0] s);
`ifdef IFFT_BFLY_SCALE_EN
      return s[SW-1:2];
`else
      return s[H-1:0];
`endif
   endfunction

   assign in_ready  = (state_q == S_IDLE) || ((state_q == S_OUT) && out_ready);
   assign accept    = in_valid && in_ready;
   assign out_valid = out_valid_q;
   assign out0      = out0_q;
   assign out1      = out1_q;
   assign out2      = out2_q;
   assign out3      = out3_q;

   // Shared complex multiplier x*conj(w): the operand pair is chosen by state.
   // The product is kept at full precision and truncated to bits [WIDTH-2:H-1].
   always_comb begin
      mul_x = b_q;
      mul_w = w0_q;
      case (state_q)
         S_MUL1:  begin mul_x = c_q; mul_w = w1_q; end
         S_MUL2:  begin mul_x = d_q; mul_w = w2_q; end
         default: begin mul_x = b_q; mul_w = w0_q; end
      endcase
      mul_xr = {{(PW-H){mul_x[WIDTH-1]}}, mul_x[WIDTH-1:H]};
      mul_xi = {{(PW-H){mul_x[H-1]}}, mul_x[H-1:0]};
      mul_wr = {{(PW-H-1){mul_w[PW-1]}}, mul_w[PW-1:H+1]};
      mul_wi = {{(PW-H-1){mul_w[H]}}, mul_w[H:0]};
      prod_r = mul_xr * mul_wr + mul_xi * mul_wi;
      prod_i = mul_xi * mul_wr - mul_xr * mul_wi;
      mul_t  = {prod_r[WIDTH-2:H-1], prod_i[WIDTH-2:H-1]};
   end

   // Radix-4 combine with conjugate rotation roles; sums formed two bits wide.
   always_comb begin
      s0r = ext_h(a_q[WIDTH-1:H]) + ext_h(t1_q[WIDTH-1:H]) + ext_h(t2_q[WIDTH-1:H]) + ext_h(t3_q[WIDTH-1:H]);
      s0i = ext_h(a_q[H-1:0])     + ext_h(t1_q[H-1:0])     + ext_h(t2_q[H-1:0])     + ext_h(t3_q[H-1:0]);
      s1r = ext_h(a_q[WIDTH-1:H]) - ext_h(t1_q[H-1:0])     - ext_h(t2_q[WIDTH-1:H]) + ext_h(t3_q[H-1:0]);
      s1i = ext_h(a_q[H-1:0])     + ext_h(t1_q[WIDTH-1:H]) - ext_h(t2_q[H-1:0])     - ext_h(t3_q[WIDTH-1:H]);
      s2r = ext_h(a_q[WIDTH-1:H]) - ext_h(t1_q[WIDTH-1:H]) + ext_h(t2_q[WIDTH-1:H]) - ext_h(t3_q[WIDTH-1:H]);
      s2i = ext_h(a_q[H-1:0])     - ext_h(t1_q[H-1:0])     + ext_h(t2_q[H-1:0])     - ext_h(t3_q[H-1:0]);
      s3r = ext_h(a_q[WIDTH-1:H]) + ext_h(t1_q[H-1:0])     - ext_h(t2_q[WIDTH-1:H]) - ext_h(t3_q[H-1:0]);
      s3i = ext_h(a_q[H-1:0])     - ext_h(t1_q[WIDTH-1:H]) - ext_h(t2_q[H-1:0])     + ext_h(t3_q[WIDTH-1:H]);
   end

   // Next-state and register update logic; everything holds unless changed below.
   always_comb begin
      state_d     = state_q;
      a_d         = a_q;
      b_d         = b_q;
      c_d         = c_q;
      d_d         = d_q;
      w0_d        = w0_q;
      w1_d        = w1_q;
      w2_d        = w2_q;
      t1_d        = t1_q;
      t2_d        = t2_q;
      t3_d        = t3_q;
      out0_d      = out0_q;
      out1_d      = out1_q;
      out2_d      = out2_q;
      out3_d      = out3_q;
      out_valid_d = out_valid_q;

      if (accept) begin
         a_d  = a;
         b_d  = b;
         c_d  = c;
         d_d  = d;
         w0_d = w0;
         w1_d = w1;
         w2_d = w2;
      end

      case (state_q)
         S_IDLE: begin
            if (accept) state_d = S_MUL0;
         end
         S_MUL0: begin
            t1_d    = mul_t;
            state_d = S_MUL1;
         end
         S_MUL1: begin
            t2_d    = mul_t;
            state_d = S_MUL2;
         end
         S_MUL2: begin
            t3_d    = mul_t;
            state_d = S_SUM;
         end
         S_SUM: begin
            out0_d      = {fit(s0r), fit(s0i)};
            out1_d      = {fit(s1r), fit(s1i)};
            out2_d      = {fit(s2r), fit(s2i)};
            out3_d      = {fit(s3r), fit(s3i)};
            out_valid_d = 1'b1;
            state_d     = S_OUT;
         end
         S_OUT: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = accept ? S_MUL0 : S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and datapath registers; reset aborts any set in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         a_q         <= '0;
         b_q         <= '0;
         c_q         <= '0;
         d_q         <= '0;
         w0_q        <= '0;
         w1_q        <= '0;
         w2_q        <= '0;
         t1_q        <= '0;
         t2_q        <= '0;
         t3_q        <= '0;
         out0_q      <= '0;
         out1_q      <= '0;
         out2_q      <= '0;
         out3_q      <= '0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         a_q         <= a_d;
         b_q         <= b_d;
         c_q         <= c_d;
         d_q         <= d_d;
         w0_q        <= w0_d;
         w1_q        <= w1_d;
         w2_q        <= w2_d;
         t1_q        <= t1_d;
         t2_q        <= t2_d;
         t3_q        <= t3_d;
         out0_q      <= out0_d;
         out1_q      <= out1_d;
         out2_q      <= out2_d;
         out3_q      <= out3_d;
         out_valid_q <= out_valid_d;
      end
   end

endmodule

// File: tb/tb_ifft_butterfly_4_seq.sv
// Self-checking bench for ifft_butterfly_4_seq.
// An integer model computes the expected results for each operand set.
// Each expected result is queued when its set is accepted, then popped and
// compared when the result is handed off.
module tb_ifft_butterfly_4_seq;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] a, b, c, d;
   logic [33:0] w0, w1, w2;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out0, out1, out2, out3;

   int           vectors     = 0;
   int           miscompares = 0;
   logic [127:0] exp_q[$];

   localparam logic [33:0] W_ONE = 34'h1_0000_0000;
   localparam logic [33:0] W_J   = 34'h0_0000_8000;

   ifft_butterfly_4_seq #(.WIDTH(32)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .c(c), .d(d), .w0(w0), .w1(w1), .w2(w2),
      .out_valid(out_valid), .out_ready(out_ready),
      .out0(out0), .out1(out1), .out2(out2), .out3(out3)
   );

   always #5 clk = ~clk;

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [15:0] sc(input int v);
      logic [31:0] s;
`ifdef IFFT_BFLY_SCALE_EN
      s = v >>> 2;
`else
      s = v;
`endif
      return s[15:0];
   endfunction

   function automatic logic [31:0] cx(input int re, input int im);
      return {sc(re), sc(im)};
   endfunction

   function automatic logic [127:0] model(input logic [31:0] ia, ib, ic, id,
                                          input logic [33:0] iw0, iw1, iw2);
      logic [31:0] xs[3];
      logic [33:0] ws[3];
      int          tr[3], ti[3];
      int          ar, ai;
      longint      xr, xi, wr, wi, pr, pi;
      logic [15:0] h;
      xs[0] = ib; xs[1] = ic; xs[2] = id;
      ws[0] = iw0; ws[1] = iw1; ws[2] = iw2;
      for (int k = 0; k < 3; k++) begin
         xr = longint'($signed(xs[k][31:16]));
         xi = longint'($signed(xs[k][15:0]));
         wr = longint'($signed(ws[k][33:17]));
         wi = longint'($signed(ws[k][16:0]));
         pr = (xr * wr + xi * wi) >>> 15;
         pi = (xi * wr - xr * wi) >>> 15;
         h = pr[15:0]; tr[k] = int'($signed(h));
         h = pi[15:0]; ti[k] = int'($signed(h));
      end
      ar = int'($signed(ia[31:16]));
      ai = int'($signed(ia[15:0]));
      return {sc(ar + tr[0] + tr[1] + tr[2]), sc(ai + ti[0] + ti[1] + ti[2]),
              sc(ar - ti[0] - tr[1] + ti[2]), sc(ai + tr[0] - ti[1] - tr[2]),
              sc(ar - tr[0] + tr[1] - tr[2]), sc(ai - ti[0] + ti[1] - ti[2]),
              sc(ar + ti[0] - tr[1] - ti[2]), sc(ai - tr[0] - ti[1] + tr[2])};
   endfunction

   function automatic logic [33:0] rand_w();
      int          r, i;
      logic [33:0] v;
      r = int'($urandom_range(0, 65536)) - 32768;
      i = int'($urandom_range(0, 65536)) - 32768;
      if ($urandom_range(0, 7) == 0) r = 32768;
      if ($urandom_range(0, 7) == 0) i = -32768;
      v = {r[16:0], i[16:0]};
      return v;
   endfunction

   // Offer one set, wait (bounded) for in_ready, then scramble the inputs.
   task automatic drive_set(input logic [31:0] ia, ib, ic, id, input logic [33:0] iw0, iw1, iw2);
      int n = 0;
      a = ia; b = ib; c = ic; d = id; w0 = iw0; w1 = iw1; w2 = iw2;
      in_valid = 1'b1;
      while (in_ready !== 1'b1 && n < 50) begin
         @(posedge clk); #1; n++;
      end
      if (n >= 50) begin
         miscompares++;
         $display("FAIL drive_set: in_ready got %b want 1 within 50 cycles", in_ready);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      exp_q.push_back(model(ia, ib, ic, id, iw0, iw1, iw2));
      a = $urandom; b = $urandom; c = $urandom; d = $urandom;
      w0 = rand_w(); w1 = rand_w(); w2 = rand_w();
   endtask

   // Count edges until out_valid rises (bounded at 40).
   task automatic wait_valid(output int lat);
      lat = 0;
      while (out_valid !== 1'b1 && lat < 40) begin
         @(posedge clk); #1; lat++;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      a = '0; b = '0; c = '0; d = '0; w0 = '0; w1 = '0; w2 = '0;
      #12;
      vectors++;
      if (out_valid !== 1'b0) begin
         miscompares++; $display("FAIL reset_out_valid: got %b want 0", out_valid);
      end
      vectors++;
      if ({out0, out1, out2, out3} !== 128'h0) begin
         miscompares++; $display("FAIL reset_outputs: got %h want 0", {out0, out1, out2, out3});
      end
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      vectors++;
      if (in_ready !== 1'b1) begin
         miscompares++; $display("FAIL reset_in_ready: got %b want 1", in_ready);
      end
   endtask

   typedef struct {
      string        name;
      logic [31:0]  a, b, c, d;
      logic [33:0]  w0, w1, w2;
      logic [127:0] want;
   } vec_t;

   task automatic test_directed();
      vec_t         tbl[4];
      int           lat;
      logic [127:0] e;
      tbl[0] = '{"impulse",  32'h1000_0000, 32'h0, 32'h0, 32'h0, W_ONE, W_ONE, W_ONE,
                 {cx(4096, 0), cx(4096, 0), cx(4096, 0), cx(4096, 0)}};
      tbl[1] = '{"dc",       32'h0400_0000, 32'h0400_0000, 32'h0400_0000, 32'h0400_0000, W_ONE, W_ONE, W_ONE,
                 {cx(4096, 0), cx(0, 0), cx(0, 0), cx(0, 0)}};
      tbl[2] = '{"rotation", 32'h0, 32'h0000_0400, 32'h0, 32'h0, W_ONE, W_ONE, W_ONE,
                 {cx(0, 1024), cx(-1024, 0), cx(0, -1024), cx(1024, 0)}};
      tbl[3] = '{"conjugate", 32'h0, 32'h0400_0000, 32'h0, 32'h0, W_J, W_ONE, W_ONE,
                 {cx(0, -1024), cx(1024, 0), cx(0, 1024), cx(-1024, 0)}};
      out_ready = 1'b1;
      foreach (tbl[i]) begin
         drive_set(tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].d, tbl[i].w0, tbl[i].w1, tbl[i].w2);
         wait_valid(lat);
         vectors++;
         if (lat != 4) begin
            miscompares++; $display("FAIL %s_latency: got %0d edges want 4", tbl[i].name, lat);
         end
         e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
         vectors++;
         if ({out0, out1, out2, out3} !== e) begin
            miscompares++; $display("FAIL %s_model: got %h want %h", tbl[i].name, {out0, out1, out2, out3}, e);
         end
         vectors++;
         if ({out0, out1, out2, out3} !== tbl[i].want) begin
            miscompares++; $display("FAIL %s_const: got %h want %h", tbl[i].name, {out0, out1, out2, out3}, tbl[i].want);
         end
         @(posedge clk); #1;
         vectors++;
         if (out_valid !== 1'b0) begin
            miscompares++; $display("FAIL %s_handshake: out_valid got %b want 0", tbl[i].name, out_valid);
         end
      end
   endtask

   task automatic test_backpressure();
      int           lat;
      int           bad_v = 0, bad_d = 0, bad_r = 0;
      logic [127:0] held, e;
      out_ready = 1'b0;
      drive_set(32'h0100_0200, 32'h0300_FF00, 32'hF000_0123, 32'h7FFF_8000, rand_w(), rand_w(), rand_w());
      wait_valid(lat);
      vectors++;
      if (lat != 4) begin
         miscompares++; $display("FAIL bp_latency: got %0d edges want 4", lat);
      end
      held = {out0, out1, out2, out3};
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
      vectors++;
      if (held !== e) begin
         miscompares++; $display("FAIL bp_model: got %h want %h", held, e);
      end
      repeat (10) begin
         @(posedge clk); #1;
         if (out_valid !== 1'b1) bad_v++;
         if ({out0, out1, out2, out3} !== held) bad_d++;
         if (in_ready !== 1'b0) bad_r++;
      end
      vectors++;
      if (bad_v != 0) begin
         miscompares++; $display("FAIL bp_hold_valid: %0d cycles low, want 0", bad_v);
      end
      vectors++;
      if (bad_d != 0) begin
         miscompares++; $display("FAIL bp_hold_data: %0d cycles changed, want 0", bad_d);
      end
      vectors++;
      if (bad_r != 0) begin
         miscompares++; $display("FAIL bp_in_ready: %0d cycles high, want 0", bad_r);
      end
      a = 32'h1234_0567; b = 32'h2000_E000; c = 32'h0F00_F100; d = 32'h4000_0400;
      w0 = W_ONE; w1 = W_J; w2 = 34'h3_0000_8000;
      in_valid = 1'b1; out_ready = 1'b1;
      #1;
      vectors++;
      if (in_ready !== 1'b1) begin
         miscompares++; $display("FAIL bp_same_edge_ready: got %b want 1", in_ready);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      exp_q.push_back(model(32'h1234_0567, 32'h2000_E000, 32'h0F00_F100, 32'h4000_0400,
                            W_ONE, W_J, 34'h3_0000_8000));
      a = $urandom; b = $urandom;
      vectors++;
      if (out_valid !== 1'b0) begin
         miscompares++; $display("FAIL bp_release: out_valid got %b want 0", out_valid);
      end
      wait_valid(lat);
      vectors++;
      if (lat != 4) begin
         miscompares++; $display("FAIL bp_next_latency: got %0d edges want 4", lat);
      end
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
      vectors++;
      if ({out0, out1, out2, out3} !== e) begin
         miscompares++; $display("FAIL bp_next_model: got %h want %h", {out0, out1, out2, out3}, e);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid();
      int           lat, seen = 0;
      logic [127:0] e;
      out_ready = 1'b1;
      drive_set($urandom, $urandom, $urandom, $urandom, rand_w(), rand_w(), rand_w());
      @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      vectors++;
      if (out_valid !== 1'b0) begin
         miscompares++; $display("FAIL rstmid_valid: got %b want 0", out_valid);
      end
      vectors++;
      if ({out0, out1, out2, out3} !== 128'h0) begin
         miscompares++; $display("FAIL rstmid_outputs: got %h want 0", {out0, out1, out2, out3});
      end
      exp_q.delete();
      @(negedge clk); rst_n = 1'b1;
      #1;
      vectors++;
      if (in_ready !== 1'b1) begin
         miscompares++; $display("FAIL rstmid_in_ready: got %b want 1", in_ready);
      end
      repeat (12) begin
         @(posedge clk); #1;
         if (out_valid !== 1'b0) seen++;
      end
      vectors++;
      if (seen != 0) begin
         miscompares++; $display("FAIL rstmid_stale: out_valid high %0d cycles, want 0", seen);
      end
      drive_set(32'h0800_F800, 32'h0100_0100, 32'hFF00_0080, 32'h0040_FFC0, rand_w(), rand_w(), rand_w());
      wait_valid(lat);
      vectors++;
      if (lat != 4) begin
         miscompares++; $display("FAIL rstmid_recover_latency: got %0d edges want 4", lat);
      end
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
      vectors++;
      if ({out0, out1, out2, out3} !== e) begin
         miscompares++; $display("FAIL rstmid_recover_model: got %h want %h", {out0, out1, out2, out3}, e);
      end
      @(posedge clk); #1;
   endtask

   // Streaming: rnd=0 keeps both sides always ready and checks the 5-cycle
   // cadence; rnd=1 randomises in_valid and out_ready.
   task automatic test_stream(input bit rnd, input int nsets);
      int           sent = 0, got = 0, cyc = 0, last = -1;
      bit           hs_in, hs_out;
      logic [127:0] e;
      in_valid = 1'b0;
      while ((sent < nsets || got < sent) && cyc < 3000) begin
         if (!in_valid && sent < nsets && (!rnd || $urandom_range(0, 3) != 0)) begin
            a = $urandom; b = $urandom; c = $urandom; d = $urandom;
            w0 = rand_w(); w1 = rand_w(); w2 = rand_w();
            in_valid = 1'b1;
         end
         out_ready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
         #1;
         hs_out = out_valid && out_ready;
         hs_in  = in_valid && in_ready;
         if (hs_out) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
            vectors++;
            if ({out0, out1, out2, out3} !== e) begin
               miscompares++; $display("FAIL stream_data[%0d]: got %h want %h", got, {out0, out1, out2, out3}, e);
            end
            if (!rnd && last >= 0) begin
               vectors++;
               if (cyc - last != 5) begin
                  miscompares++; $display("FAIL stream_cadence[%0d]: got %0d cycles want 5", got, cyc - last);
               end
            end
            last = cyc;
            got++;
         end
         if (hs_in) begin
            exp_q.push_back(model(a, b, c, d, w0, w1, w2));
            sent++;
         end
         @(posedge clk); #1;
         if (hs_in) in_valid = 1'b0;
         cyc++;
      end
      in_valid = 1'b0;
      vectors++;
      if (got != nsets) begin
         miscompares++; $display("FAIL stream_count: got %0d results want %0d", got, nsets);
      end
      vectors++;
      if (exp_q.size() != 0) begin
         miscompares++; $display("FAIL stream_leftover: got %0d pending want 0", exp_q.size());
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_backpressure();
      test_reset_mid();
      test_stream(1'b0, 4);
      test_stream(1'b1, 40);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
